// File: rtl/clk_div_rst_seq.sv
// PLL reset / lock sequencer with staggered per-channel reset release and programmable dividers.
// Optional lock timeout is built when CLK_DIV_RST_SEQ_TIMEOUT_EN is defined.
module clk_div_rst_seq #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned PRST_CYC  = 16,
  parameter int unsigned LOCK_FILT = 32,
  parameter int unsigned STAGE_DLY = 8,
  parameter int unsigned TMO_CYC   = 4096
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              LOCK_IN,
  input  logic              CHG,
  input  logic [NCH*DW-1:0] DIV,
  output logic              PLL_RST,
  output logic              LOCKED,
  output logic              BUSY,
  output logic [NCH-1:0]    RSTXO,
  output logic [NCH-1:0]    CLKO,
  output logic [NCH-1:0]    STB,
  output logic              TIMEOUT
);

  if (NCH < 1 || NCH > 8 || DW < 1 || PRST_CYC < 1 || LOCK_FILT < 1 || STAGE_DLY < 1 ||
      TMO_CYC < 1) begin : g_param_check
    $error("clk_div_rst_seq: illegal parameter value");
  end

  localparam logic [1:0] StPrst = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StRel  = 2'd2;
  localparam logic [1:0] StRun  = 2'd3;

  localparam int unsigned PW = $clog2(PRST_CYC + 1);
  localparam int unsigned FW = $clog2(LOCK_FILT + 1);
  localparam int unsigned SW = $clog2(STAGE_DLY + 1);

  localparam logic [PW-1:0] PrstLast  = PW'(PRST_CYC - 1);
  localparam logic [FW-1:0] FiltLast  = FW'(LOCK_FILT - 1);
  localparam logic [SW-1:0] StageLast = SW'(STAGE_DLY - 1);

  logic [1:0]     state_q, state_d;
  logic [1:0]     sync_q, sync_d;
  logic           lock_s;
  logic [PW-1:0]  prst_cnt_q, prst_cnt_d;
  logic [FW-1:0]  filt_q, filt_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [NCH-1:0] rstxo_q, rstxo_d;
  logic [NCH-1:0] clko_q, clko_d;
  logic [NCH-1:0] stb_q, stb_d;
  logic [DW-1:0]  div_q [NCH];
  logic [DW-1:0]  div_d [NCH];
  logic [DW-1:0]  cnt_q [NCH];
  logic [DW-1:0]  cnt_d [NCH];

`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TMO_CYC - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
`endif

  assign sync_d = {sync_q[0], LOCK_IN};
  assign lock_s = sync_q[1];

  // Sequencer. Channel resets form a thermometer code, so releasing the next channel is a
  // shift-in of a one.
  always_comb begin
    state_d    = state_q;
    prst_cnt_d = '0;
    filt_d     = '0;
    stage_d    = '0;
    rstxo_d    = rstxo_q;
`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
    tmo_d      = '0;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      StPrst: begin
        if (prst_cnt_q == PrstLast) begin
          state_d = StWait;
        end else begin
          prst_cnt_d = prst_cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (lock_s && (filt_q == FiltLast)) begin
          state_d = StRel;
          rstxo_d = NCH'(1);
        end
`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          state_d   = StPrst;
          timeout_d = 1'b1;
        end
`endif
        else begin
          filt_d = lock_s ? filt_q + 1'b1 : '0;
`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
          tmo_d  = tmo_q + 1'b1;
`endif
        end
      end
      StRel: begin
        if (!lock_s) begin
          state_d = StWait;
          rstxo_d = '0;
        end else if (rstxo_q[NCH-1]) begin
          state_d = StRun;
        end else if (stage_q == StageLast) begin
          rstxo_d = (rstxo_q << 1) | NCH'(1);
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWait;
          rstxo_d = '0;
        end
      end
    endcase

    // Reconfiguration wins over lock loss; ignored while the PLL is already in reset.
    if (CHG && (state_q != StPrst)) begin
      state_d = StPrst;
      rstxo_d = '0;
    end
`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
    if (state_d == StRun) begin
      timeout_d = 1'b0;
    end
`endif
  end

  // Dividers follow the next-state reset so lock loss / CHG clear them on the same edge.
  always_comb begin
    div_d  = div_q;
    clko_d = '0;
    stb_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (rstxo_d[i]) begin
        if (!rstxo_q[i]) begin
          div_d[i] = DIV[i*DW +: DW];
        end else if (cnt_q[i] == div_q[i]) begin
          clko_d[i] = ~clko_q[i];
          stb_d[i]  = ~clko_q[i];
        end else begin
          cnt_d[i]  = cnt_q[i] + 1'b1;
          clko_d[i] = clko_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state_q    <= StPrst;
      sync_q     <= '0;
      prst_cnt_q <= '0;
      filt_q     <= '0;
      stage_q    <= '0;
      rstxo_q    <= '0;
      clko_q     <= '0;
      stb_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prst_cnt_q <= prst_cnt_d;
      filt_q     <= filt_d;
      stage_q    <= stage_d;
      rstxo_q    <= rstxo_d;
      clko_q     <= clko_d;
      stb_q      <= stb_d;
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
      tmo_q      <= tmo_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign PLL_RST = (state_q == StPrst);
  assign LOCKED  = (state_q == StRun);
  assign BUSY    = (state_q != StRun);
  assign RSTXO   = rstxo_q;
  assign CLKO    = clko_q;
  assign STB     = stb_q;

`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_rst_seq.sv
// Bench for clk_div_rst_seq: phase/time-based reference model checked every cycle, directed
// sequences with literal expectations, then randomized lock/CHG/reset/DIV stimulus.
module tb_clk_div_rst_seq;

  localparam int unsigned NCH       = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned PRST_CYC  = 16;
  localparam int unsigned LOCK_FILT = 32;
  localparam int unsigned STAGE_DLY = 8;
  localparam int unsigned TMO_CYC   = 100;
`ifdef CLK_DIV_RST_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif
  localparam int unsigned OW = 4 + 3 * NCH;

  logic              clk = 1'b0;
  logic              rstx;
  logic              lock_in;
  logic              chg;
  logic [NCH*DW-1:0] div;
  logic              pll_rst;
  logic              locked;
  logic              busy;
  logic [NCH-1:0]    rstxo;
  logic [NCH-1:0]    clko;
  logic [NCH-1:0]    stb;
  logic              timeout;

  always #5 clk = ~clk;

  clk_div_rst_seq #(
    .NCH      (NCH),
    .DW       (DW),
    .PRST_CYC (PRST_CYC),
    .LOCK_FILT(LOCK_FILT),
    .STAGE_DLY(STAGE_DLY),
    .TMO_CYC  (TMO_CYC)
  ) u_dut (
    .CLK    (clk),
    .RSTX   (rstx),
    .LOCK_IN(lock_in),
    .CHG    (chg),
    .DIV    (div),
    .PLL_RST(pll_rst),
    .LOCKED (locked),
    .BUSY   (busy),
    .RSTXO  (rstxo),
    .CLKO   (clko),
    .STB    (stb),
    .TIMEOUT(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: phase plus time-in-phase; channel outputs from elapsed time since release.
  typedef enum int {PhPrst, PhWait, PhRel, PhRun} phase_e;

  phase_e         ph = PhPrst;
  int             pt = 0;
  int             consec = 0;
  bit             l1 = 1'b0;
  bit             l2 = 1'b0;
  bit             m_to = 1'b0;
  bit             m_valid = 1'b0;
  longint         cyc = 0;
  bit             m_r [NCH];
  int             m_div [NCH];
  longint         m_rel [NCH];
  logic [NCH-1:0] e_rstxo, e_clko, e_stb;

  task automatic model_step();
    bit     ls;
    phase_e nxt;
    int     npt;
    cyc++;
    if (!rstx) begin
      ph = PhPrst; pt = 0; consec = 0; l1 = 1'b0; l2 = 1'b0; m_to = 1'b0; m_valid = 1'b1;
    end else begin
      ls = l2; l2 = l1; l1 = lock_in;
      nxt = ph;
      npt = pt + 1;
      case (ph)
        PhPrst: if (pt == PRST_CYC - 1) nxt = PhWait;
        PhWait: begin
          consec = ls ? consec + 1 : 0;
          if (consec == LOCK_FILT) nxt = PhRel;
          else if (TmoEn && pt == TMO_CYC - 1) begin
            nxt  = PhPrst;
            m_to = 1'b1;
          end
        end
        PhRel: begin
          if (!ls) nxt = PhWait;
          else if (pt == (NCH - 1) * STAGE_DLY) nxt = PhRun;
        end
        default: if (!ls) nxt = PhWait;
      endcase
      if (chg && ph != PhPrst) nxt = PhPrst;
      if (nxt != ph) begin
        npt    = 0;
        consec = 0;
      end
      if (nxt == PhRun) m_to = 1'b0;
      ph = nxt;
      pt = npt;
    end
    for (int i = 0; i < NCH; i++) begin
      bit     r;
      longint dt;
      int     d;
      r = (ph == PhRun) || (ph == PhRel && pt >= i * STAGE_DLY);
      if (r && !m_r[i]) begin
        m_div[i] = int'(div[i*DW +: DW]);
        m_rel[i] = cyc;
      end
      m_r[i]     = r;
      d          = m_div[i];
      dt         = cyc - m_rel[i];
      e_rstxo[i] = r;
      e_clko[i]  = r && ((dt / (d + 1)) % 2 == 1);
      e_stb[i]   = r && (dt > 0) && (dt % (2 * (d + 1)) == d + 1);
    end
  endtask

  initial begin
    logic [OW-1:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_valid) begin
        exp_v = {ph == PhPrst, ph == PhRun, ph != PhRun, m_to, e_rstxo, e_clko, e_stb};
        got_v = {pll_rst, locked, busy, timeout, rstxo, clko, stb};
        check("model_outputs", longint'(got_v), longint'(exp_v));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_locked(input string name);
    int n;
    n = 0;
    while (!locked && n < 400) begin
      n++;
      tick(1);
    end
    check(name, locked, 1);
  endtask

  initial begin
    int n;
    int exp_per [NCH];
    exp_per = '{2, 4, 8, 20};
    rstx    = 1'b0;
    lock_in = 1'b0;
    chg     = 1'b0;
    div     = {8'd9, 8'd3, 8'd1, 8'd0};
    tick(3);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_rstxo", rstxo, 0);
    check("rst_busy", busy, 1);
    check("rst_locked", locked, 0);

    // Bring-up: PLL_RST 16 cycles; lock rises as PLL_RST falls, so 2 sync + 32 filter.
    rstx = 1'b1;
    n = 0;
    while (pll_rst && n < 200) begin n++; tick(1); end
    check("prst_len", n, 16);
    lock_in = 1'b1;
    n = 0;
    while (!rstxo[0] && n < 200) begin n++; tick(1); end
    check("rel0_delay", n, 34);
    for (int k = 1; k < NCH; k++) begin
      n = 0;
      while (!rstxo[k] && n < 100) begin n++; tick(1); end
      check("rel_stagger", n, 8);
    end
    tick(1);
    check("locked_after_last", locked, 1);
    n = 1;
    while (!stb[3] && n < 100) begin n++; tick(1); end
    check("ch3_first_rise", n, 10);
    check("ch3_clko_at_stb", clko[3], 1);

    for (int ch = 0; ch < NCH; ch++) begin
      n = 0;
      while (!stb[ch] && n < 100) begin n++; tick(1); end
      tick(1);
      check("stb_width", stb[ch], 0);
      n = 1;
      while (!stb[ch] && n < 100) begin n++; tick(1); end
      check("clko_period", n, exp_per[ch]);
    end

    // DIV changes while running must be ignored.
    div = {8'd2, 8'd7, 8'd0, 8'd5};
    tick(40);

    // One-cycle lock glitch in RUN.
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    n = 1;
    while (rstxo != 0 && n < 20) begin n++; tick(1); end
    check("loss_latency", n, 3);
    check("loss_no_pll_rst", pll_rst, 0);
    check("loss_busy", busy, 1);

    // Glitch in WAIT at filter count 20: release at 32 + 21 cycles after WAIT entry.
    tick(18);
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    n = 19;
    while (!rstxo[0] && n < 200) begin n++; tick(1); end
    check("wait_glitch_rel", n, 53);
    wait_locked("relock_after_glitch");

    // CHG in RUN, second CHG during PRST ignored.
    chg = 1'b1;
    tick(1);
    chg = 1'b0;
    check("chg_rstxo", rstxo, 0);
    n = 0;
    while (pll_rst && n < 200) begin
      chg = (n == 4);
      n++;
      tick(1);
    end
    chg = 1'b0;
    check("chg_prst_len", n, 16);
    wait_locked("relock_after_chg");

    // CHG coinciding with lock loss goes to PRST.
    lock_in = 1'b0;
    tick(2);
    chg = 1'b1;
    tick(1);
    chg = 1'b0;
    lock_in = 1'b1;
    check("chg_vs_loss_pll_rst", pll_rst, 1);
    check("chg_vs_loss_rstxo", rstxo, 0);

    // Reset pulse mid-REL at k=2.
    n = 0;
    while (!rstxo[2] && n < 400) begin n++; tick(1); end
    check("reach_k2", rstxo, 4'b0111);
    rstx = 1'b0;
    tick(1);
    rstx = 1'b1;
    check("midrel_rst_outs", {pll_rst, locked, busy, rstxo, clko, stb}, {3'b101, 12'h000});
    n = 0;
    while (pll_rst && n < 200) begin n++; tick(1); end
    check("midrel_prst_len", n, 16);
    wait_locked("relock_after_rst");

    // Randomized phase, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      lock_in = ($urandom_range(0, 99) != 0);
      chg     = ($urandom_range(0, 299) == 0);
      rstx    = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 49) == 0) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if ($urandom_range(0, 3) == 0) div[ch*DW +: DW] = 8'($urandom_range(0, 255));
          else div[ch*DW +: DW] = 8'($urandom_range(0, 5));
        end
      end
      tick(1);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_rst_seq.md
Name: clk_div_rst_seq

Overview:
Parametrised successor to the single-PLL clock/reset controller. Sequences PLL reset and lock qualification, then releases NCH channel resets in a staggered order. Generates NCH divided clocks with runtime-selectable ratios, each with a rising-edge strobe. Sits between the PLL primitive and the fabric domains; handles lock loss and reconfiguration requests, which the previous generation did not.

Parameters:
NCH, 4, number of output channels (1..8)
DW, 8, divider field width per channel
PRST_CYC, 16, PLL_RST assertion length in cycles (>=1)
LOCK_FILT, 32, consecutive synchronized-lock cycles required before release (>=1)
STAGE_DLY, 8, cycles between successive channel reset releases (>=1)
TMO_CYC, 4096, lock timeout in cycles (used only with the optional feature)

Ports:
CLK  in  1  single clock; all logic is on its rising edge
RSTX  in  1  synchronous, active-low reset
LOCK_IN  in  1  PLL lock, asynchronous; 2-flop synchronized internally
CHG  in  1  one-cycle reconfiguration request; forces a full PLL reset sequence
DIV  in  NCH*DW  per-channel half-period minus one; channel i uses DIV[i*DW +: DW]
PLL_RST  out  1  active-high PLL reset
LOCKED  out  1  high in RUN only
BUSY  out  1  high in any state other than RUN
RSTXO  out  NCH  per-channel active-low reset
CLKO  out  NCH  divided clocks
STB  out  NCH  one-cycle pulse in the cycle CLKO[i] goes 0->1
TIMEOUT  out  1  sticky lock-timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- RSTX low at a rising CLK edge: state=PRST, PLL_RST=1, RSTXO=0, CLKO=0, STB=0, LOCKED=0, BUSY=1, all counters 0, synchronizer flops 0. Reset asserted mid-sequence behaves identically.
- lock_s is LOCK_IN after 2 flops (2-cycle latency).
- PRST: PLL_RST=1 for exactly PRST_CYC cycles, then WAIT. PLL_RST is 0 in every state except PRST.
- WAIT: filter counter increments while lock_s=1 and clears to 0 while lock_s=0. On reaching LOCK_FILT go to REL with k=0; the first release happens in that transition cycle.
- REL: RSTXO[k] goes 1, then k increments every STAGE_DLY cycles. Channels release in order 0..NCH-1. After RSTXO[NCH-1] is released, go to RUN on the next cycle.
- RUN: LOCKED=1, BUSY=0.
- Lock loss: lock_s=0 in REL or RUN drives all RSTXO, CLKO and STB to 0 on the next edge and returns to WAIT. There is no PLL reset.
- CHG=1 in any state except PRST: go to PRST, RSTXO=0, CLKO=0. CHG during PRST is ignored and does not restart the count. CHG has priority over lock loss in the same cycle.
- Divider i: DIV field latched into div_q[i] in the cycle RSTXO[i] rises. DIV changes while running are ignored until the next release.
- Counter cnt[i] starts at 0. When cnt[i]==div_q[i], CLKO[i] toggles and cnt clears; otherwise cnt increments. Period = 2*(div_q+1) cycles.
- DIV=0 gives CLK/2. First CLKO[i] rise occurs div_q+1 cycles after release.
- STB[i] is registered and aligned with the CLKO[i] 0->1 edge. Dividers are held (cnt=0, CLKO=0) while RSTXO[i]=0.
- NCH=1: REL lasts one cycle.

Optional Feature:
Macro CLK_DIV_RST_SEQ_TIMEOUT_EN.
- Defined: a WAIT counter counts cycles since entering WAIT. On reaching TMO_CYC without qualifying lock, go to PRST and set TIMEOUT=1. TIMEOUT is sticky until RSTX or until RUN is reached.
- Undefined: WAIT waits indefinitely; TIMEOUT is tied 0 and no timeout counter is instantiated.

Test Plan:
- Reset release with LOCK_IN=1, NCH=4, PRST_CYC=16, LOCK_FILT=32, STAGE_DLY=8 -> PLL_RST high 16 cycles. RSTXO[0] rises after 2+32 further cycles. RSTXO[1..3] follow at +8, +16, +24. LOCKED=1 one cycle after RSTXO[3].
- DIV={8'd0,8'd1,8'd3,8'd9} -> CLKO periods 2/4/8/20 cycles. STB one cycle wide on each rise. First rise at div+1 cycles after each release.
- LOCK_IN glitch low 1 cycle during WAIT at filter count 20 -> filter restarts and release is delayed by 21+ cycles. Same glitch in RUN -> all RSTXO=0 within 3 cycles, WAIT, no PLL_RST.
- CHG pulse in RUN -> PLL_RST high 16 cycles and full resequence. Second CHG during PRST -> PLL_RST still exactly 16 cycles. CHG together with lock loss -> PRST.
- RSTX low for 1 cycle mid-REL (k=2) -> all outputs at reset values next edge; sequence restarts from PRST.
- With CLK_DIV_RST_SEQ_TIMEOUT_EN, TMO_CYC=100, LOCK_IN=0 -> PRST re-entered every 100+16 cycles and TIMEOUT=1. LOCK_IN=1 then -> RUN and TIMEOUT clears.
